// File: rtl/game_control_if.sv
// game_control_if
//   Bundles everything that passes between the tetris sequencing FSM and the
//   board/piece datapath, leaving only clock and reset as plain ports.
//   master : the sequencer (game_control). It reads the player, gravity and
//            board status inputs and drives the one-cycle datapath pulses.
//   slave  : the datapath side (board model, piece registers, key logic).
//   Signals
//     start_game, fall_tick, key_left/right/rotate   control and player inputs
//     filled_under/left/right, rotation_conflicts     piece collision status
//     spawn_blocked, completed_lines[ROWS]            board status
//     load_block, drop_block, update_board_state,
//     shift_down + shift_index, move_left/right,
//     rotate                                          datapath action pulses
//     game_over, lines_cleared                        game status levels
interface game_control_if #(
    parameter int ROWS = 20
);
    logic            start_game;
    logic            fall_tick;
    logic            key_left;
    logic            key_right;
    logic            key_rotate;
    logic            filled_under;
    logic            filled_left;
    logic            filled_right;
    logic            rotation_conflicts;
    logic            spawn_blocked;
    logic [ROWS-1:0] completed_lines;

    logic            load_block;
    logic            drop_block;
    logic            update_board_state;
    logic            shift_down;
    logic [4:0]      shift_index;
    logic            move_left;
    logic            move_right;
    logic            rotate;
    logic            game_over;
    logic [15:0]     lines_cleared;

    modport master (
        input  start_game, fall_tick, key_left, key_right, key_rotate,
               filled_under, filled_left, filled_right, rotation_conflicts,
               spawn_blocked, completed_lines,
        output load_block, drop_block, update_board_state, shift_down,
               shift_index, move_left, move_right, rotate, game_over,
               lines_cleared
    );

    modport slave (
        output start_game, fall_tick, key_left, key_right, key_rotate,
               filled_under, filled_left, filled_right, rotation_conflicts,
               spawn_blocked, completed_lines,
        input  load_block, drop_block, update_board_state, shift_down,
               shift_index, move_left, move_right, rotate, game_over,
               lines_cleared
    );
endinterface

// File: rtl/game_control.sv
// game_control
//   Sequencing FSM for the tetris board datapath: spawns pieces, paces the
//   fall, locks pieces into the board, clears completed rows one per pass and
//   detects game over. Player moves are arbitrated against gravity so that at
//   most one datapath action pulse is high in any cycle.
//   Ports
//     clock  : datapath clock (clock_framerate)
//     reset  : synchronous, active-high; overrides everything, even mid-clear
//     bus    : game_control_if.master, all datapath inputs and action outputs
//   Every output is a register: a pulse decided at one edge is visible for
//   exactly the following cycle, so load_block is high while in LOAD and
//   update_board_state is high while in LOCK.
module game_control #(
    parameter int ROWS       = 20,
    parameter int LOCK_DELAY = 1
) (
    input  logic           clock,
    input  logic           reset,
    game_control_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SPAWN_CHK,
        FALL,
        LOCK,
        CLEAR,
        SETTLE,
        OVER
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  lock_count;
    logic [3:0]  lock_count_next;
    logic        prev_left;
    logic        prev_right;
    logic        prev_rotate;
    logic        pend_left;
    logic        pend_right;
    logic        pend_rotate;
    logic        pend_left_next;
    logic        pend_right_next;
    logic        pend_rotate_next;
    logic        keep_left;
    logic        keep_right;
    logic        keep_rotate;
    logic        load_next;
    logic        drop_next;
    logic        update_next;
    logic        shift_next;
    logic        left_next;
    logic        right_next;
    logic        rotate_next;
    logic [4:0]  index_next;
    logic [15:0] lines_next;
    logic [4:0]  lowest_row;
    logic        edge_left;
    logic        edge_right;
    logic        edge_rotate;

    assign edge_left   = bus.key_left   & ~prev_left;
    assign edge_right  = bus.key_right  & ~prev_right;
    assign edge_rotate = bus.key_rotate & ~prev_rotate;

    // Lowest full row: scanning downward lets the lowest set bit win.
    always_comb begin
        lowest_row = 5'd0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (bus.completed_lines[r]) begin
                lowest_row = 5'(r);
            end
        end
    end

    // Next-state and next-output decision. Gravity beats player moves; among
    // pending moves left beats right beats rotate. A served move clears its
    // flag even when the blocked input suppresses the pulse.
    always_comb begin
        state_next      = state;
        lock_count_next = lock_count;
        load_next       = 1'b0;
        drop_next       = 1'b0;
        update_next     = 1'b0;
        shift_next      = 1'b0;
        left_next       = 1'b0;
        right_next      = 1'b0;
        rotate_next     = 1'b0;
        index_next      = 5'd0;
        lines_next      = bus.lines_cleared;
        keep_left       = pend_left;
        keep_right      = pend_right;
        keep_rotate     = pend_rotate;

        case (state)
            IDLE, OVER: begin
                if (bus.start_game) begin
                    state_next = LOAD;
                    load_next  = 1'b1;
                    lines_next = 16'd0;
                end
            end
            LOAD: begin
                state_next = SPAWN_CHK;
            end
            SPAWN_CHK: begin
                state_next = bus.spawn_blocked ? OVER : FALL;
            end
            FALL: begin
                if (bus.fall_tick) begin
                    if (!bus.filled_under) begin
                        drop_next       = 1'b1;
                        lock_count_next = 4'd0;
                    end else if ({1'b0, lock_count} + 5'd1 >= 5'(LOCK_DELAY)) begin
                        state_next      = LOCK;
                        update_next     = 1'b1;
                        lock_count_next = 4'd0;
                    end else begin
                        lock_count_next = lock_count + 4'd1;
                    end
                end else if (pend_left) begin
                    keep_left = 1'b0;
                    left_next = ~bus.filled_left;
                end else if (pend_right) begin
                    keep_right = 1'b0;
                    right_next = ~bus.filled_right;
                end else if (pend_rotate) begin
                    keep_rotate = 1'b0;
                    rotate_next = ~bus.rotation_conflicts;
                end
            end
            LOCK: begin
                state_next = CLEAR;
            end
            CLEAR: begin
                if (bus.completed_lines == '0) begin
                    state_next = LOAD;
                    load_next  = 1'b1;
                end else begin
                    state_next = SETTLE;
                    shift_next = 1'b1;
                    index_next = lowest_row;
                    if (bus.lines_cleared != 16'hFFFF) begin
                        lines_next = bus.lines_cleared + 16'd1;
                    end
                end
            end
            SETTLE: begin
                state_next = CLEAR;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Pending moves only live while the piece is falling; a new edge
        // outranks the service of the same key in that cycle.
        pend_left_next   = 1'b0;
        pend_right_next  = 1'b0;
        pend_rotate_next = 1'b0;
        if (state_next == FALL) begin
            pend_left_next   = keep_left   | edge_left;
            pend_right_next  = keep_right  | edge_right;
            pend_rotate_next = keep_rotate | edge_rotate;
        end
    end

    // State, bookkeeping and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state                  <= IDLE;
            lock_count             <= 4'd0;
            prev_left              <= 1'b0;
            prev_right             <= 1'b0;
            prev_rotate            <= 1'b0;
            pend_left              <= 1'b0;
            pend_right             <= 1'b0;
            pend_rotate            <= 1'b0;
            bus.load_block         <= 1'b0;
            bus.drop_block         <= 1'b0;
            bus.update_board_state <= 1'b0;
            bus.shift_down         <= 1'b0;
            bus.shift_index        <= 5'd0;
            bus.move_left          <= 1'b0;
            bus.move_right         <= 1'b0;
            bus.rotate             <= 1'b0;
            bus.game_over          <= 1'b0;
            bus.lines_cleared      <= 16'd0;
        end else begin
            state                  <= state_next;
            lock_count             <= lock_count_next;
            prev_left              <= bus.key_left;
            prev_right             <= bus.key_right;
            prev_rotate            <= bus.key_rotate;
            pend_left              <= pend_left_next;
            pend_right             <= pend_right_next;
            pend_rotate            <= pend_rotate_next;
            bus.load_block         <= load_next;
            bus.drop_block         <= drop_next;
            bus.update_board_state <= update_next;
            bus.shift_down         <= shift_next;
            bus.shift_index        <= index_next;
            bus.move_left          <= left_next;
            bus.move_right         <= right_next;
            bus.rotate             <= rotate_next;
            bus.game_over          <= (state_next == OVER);
            bus.lines_cleared      <= lines_next;
        end
    end

endmodule

// File: tb/tb_game_control.sv
// tb_game_control
//   Drives game_control through directed and randomized games. The driver
//   pushes the expected sequence of datapath actions into a scoreboard queue
//   from a rule-level model of the game; a separate monitor pops and compares
//   whenever the DUT raises an action pulse or game_over, and also plays the
//   board datapath (completed_lines follows locks and row shifts).
module tb_game_control;

    localparam int ROWS       = 20;
    localparam int LOCK_DELAY = 2;

    localparam int K_LOAD   = 0;
    localparam int K_DROP   = 1;
    localparam int K_UPDATE = 2;
    localparam int K_SHIFT  = 3;
    localparam int K_LEFT   = 4;
    localparam int K_RIGHT  = 5;
    localparam int K_ROTATE = 6;
    localparam int K_OVER   = 7;

    typedef struct {
        int kind;
        int idx;
        int lines;
    } event_t;

    logic clock;
    logic reset;

    event_t          sb[$];
    int              checks;
    int              failures;
    logic [ROWS-1:0] pendingMask;
    bit              doneReq;
    int              linesModel;
    int              lockModel;

    game_control_if #(.ROWS(ROWS)) bus ();

    game_control #(
        .ROWS      (ROWS),
        .LOCK_DELAY(LOCK_DELAY)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic string kindName(input int k);
        case (k)
            K_LOAD:   return "load_block";
            K_DROP:   return "drop_block";
            K_UPDATE: return "update_board_state";
            K_SHIFT:  return "shift_down";
            K_LEFT:   return "move_left";
            K_RIGHT:  return "move_right";
            K_ROTATE: return "rotate";
            K_OVER:   return "game_over";
            default:  return "none";
        endcase
    endfunction

    function automatic void expectEvent(input int k, input int idx, input int lines);
        event_t e;
        e.kind  = k;
        e.idx   = idx;
        e.lines = lines;
        sb.push_back(e);
    endfunction

    // Row-clearing rule: repeatedly remove the lowest full row and let the
    // rows above fall by one, until no full row is left or maxShifts is hit.
    function automatic int expectClears(input logic [ROWS-1:0] mask, input int maxShifts);
        bit rows[$];
        int n;
        int found;
        n = 0;
        for (int i = 0; i < ROWS; i++) rows.push_back(mask[i]);
        for (int pass = 0; pass < maxShifts; pass++) begin
            found = -1;
            for (int i = ROWS - 1; i >= 0; i--) if (rows[i]) found = i;
            if (found < 0) break;
            expectEvent(K_SHIFT, found, 0);
            rows.delete(found);
            rows.push_back(1'b0);
            n++;
        end
        return n;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic startGame();
        bus.spawn_blocked = 1'b0;
        linesModel = 0;
        lockModel  = 0;
        expectEvent(K_LOAD, 0, 0);
        bus.start_game = 1'b1;
        step();
        bus.start_game = 1'b0;
        idle(3);
    endtask

    // One gravity tick. A blocked piece that has rested LOCK_DELAY ticks
    // locks; abortClear stops the expected sequence after the first shift.
    task automatic applyTick(input bit under, input bit abortClear, output bit locked);
        int n;
        locked = 1'b0;
        bus.fall_tick    = 1'b1;
        bus.filled_under = under;
        step();
        bus.fall_tick    = 1'b0;
        bus.filled_under = 1'b0;
        if (!under) begin
            expectEvent(K_DROP, 0, 0);
            lockModel = 0;
            idle(2);
        end else begin
            lockModel++;
            if (lockModel >= LOCK_DELAY) begin
                locked    = 1'b1;
                lockModel = 0;
                expectEvent(K_UPDATE, 0, 0);
                if (abortClear) begin
                    n = expectClears(pendingMask, 1);
                end else begin
                    n = expectClears(pendingMask, ROWS);
                    linesModel = (linesModel + n > 65535) ? 65535 : linesModel + n;
                    expectEvent(K_LOAD, 0, linesModel);
                    if (bus.spawn_blocked) expectEvent(K_OVER, 0, 0);
                    idle(2 * n + 6);
                end
            end else begin
                idle(2);
            end
        end
    endtask

    // Press a set of keys together, hold them, release. Each key that rises
    // gives exactly one action, left before right before rotate, and only if
    // not blocked. withTick puts a drop between the press and the service.
    task automatic applyStimulus(input bit l, input bit r, input bit rot,
                                 input bit fl, input bit fr, input bit rc,
                                 input int hold, input bit withTick);
        int rest;
        bus.filled_left        = fl;
        bus.filled_right       = fr;
        bus.rotation_conflicts = rc;
        if (withTick) begin
            expectEvent(K_DROP, 0, 0);
            lockModel = 0;
        end
        if (l && !fl)   expectEvent(K_LEFT, 0, 0);
        if (r && !fr)   expectEvent(K_RIGHT, 0, 0);
        if (rot && !rc) expectEvent(K_ROTATE, 0, 0);
        bus.key_left   = l;
        bus.key_right  = r;
        bus.key_rotate = rot;
        step();
        rest = hold - 1;
        if (withTick) begin
            bus.fall_tick    = 1'b1;
            bus.filled_under = 1'b0;
            step();
            bus.fall_tick = 1'b0;
            rest = rest - 1;
        end
        if (rest > 0) idle(rest);
        bus.key_left   = 1'b0;
        bus.key_right  = 1'b0;
        bus.key_rotate = 1'b0;
        idle(4);
        bus.filled_left        = 1'b0;
        bus.filled_right       = 1'b0;
        bus.rotation_conflicts = 1'b0;
    endtask

    task automatic playPiece(input bit lastOne);
        bit locked;
        int nOps;
        int op;
        bit l, r, rot;
        case ($urandom_range(0, 3))
            0, 1:    pendingMask = '0;
            2:       pendingMask = ROWS'(1) << $urandom_range(0, ROWS - 1);
            default: pendingMask = ROWS'($urandom & $urandom);
        endcase
        bus.spawn_blocked = lastOne;
        locked = 1'b0;
        nOps = $urandom_range(2, 6);
        for (int i = 0; i < nOps && !locked; i++) begin
            op = $urandom_range(0, 6);
            if (op <= 3) begin
                applyTick($urandom_range(0, 3) == 0, 1'b0, locked);
            end else begin
                l   = $urandom_range(0, 1);
                r   = $urandom_range(0, 1);
                rot = $urandom_range(0, 1);
                if (!l && !r && !rot) l = 1'b1;
                applyStimulus(l, r, rot,
                              $urandom_range(0, 3) == 0,
                              $urandom_range(0, 3) == 0,
                              $urandom_range(0, 3) == 0,
                              (op == 6) ? $urandom_range(2, 4) : $urandom_range(1, 3),
                              op == 6);
            end
        end
        while (!locked) applyTick(1'b1, 1'b0, locked);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Driver: directed games followed by a randomized one.
    initial begin
        bit locked;
        bus.start_game         = 1'b0;
        bus.fall_tick          = 1'b0;
        bus.key_left           = 1'b0;
        bus.key_right          = 1'b0;
        bus.key_rotate         = 1'b0;
        bus.filled_under       = 1'b0;
        bus.filled_left        = 1'b0;
        bus.filled_right       = 1'b0;
        bus.rotation_conflicts = 1'b0;
        bus.spawn_blocked      = 1'b0;
        pendingMask = '0;
        doneReq     = 1'b0;
        linesModel  = 0;
        lockModel   = 0;
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(2);

        $display("[TB] game 1: drops, key arbitration, two-row clear, spawn blocked");
        startGame();
        for (int i = 0; i < 3; i++) applyTick(1'b0, 1'b0, locked);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b1);
        pendingMask = 20'b1010;
        bus.spawn_blocked = 1'b1;
        applyTick(1'b1, 1'b0, locked);
        applyTick(1'b1, 1'b0, locked);

        $display("[TB] game over: inputs must be ignored");
        for (int i = 0; i < 15; i++) begin
            bus.key_left   = $urandom_range(0, 1);
            bus.key_right  = $urandom_range(0, 1);
            bus.key_rotate = $urandom_range(0, 1);
            bus.fall_tick  = $urandom_range(0, 1);
            step();
        end
        bus.key_left   = 1'b0;
        bus.key_right  = 1'b0;
        bus.key_rotate = 1'b0;
        bus.fall_tick  = 1'b0;
        idle(3);

        $display("[TB] game 2: reset in the middle of a clear");
        startGame();
        applyTick(1'b0, 1'b0, locked);
        pendingMask = 20'b1010;
        applyTick(1'b1, 1'b0, locked);
        applyTick(1'b1, 1'b1, locked);
        idle(3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        linesModel = 0;
        lockModel  = 0;
        idle(3);

        $display("[TB] game 3: randomized pieces");
        startGame();
        for (int p = 0; p < 12; p++) playPiece(p == 11);
        idle(5);
        doneReq = 1'b1;
    end

    // Monitor and board model: sampled on the falling edge.
    initial begin
        int     cycles;
        bit     resetPrev;
        bit     goPrev;
        int     pulses;
        int     kind;
        event_t e;
        logic [ROWS-1:0] m;
        logic [ROWS-1:0] low;
        cycles    = 0;
        resetPrev = 1'b0;
        goPrev    = 1'b0;
        checks    = 0;
        failures  = 0;
        bus.completed_lines = '0;
        forever begin
            @(negedge clock);
            cycles++;
            if (resetPrev) begin
                checkOutput("reset load_block", int'(bus.load_block), 0);
                checkOutput("reset drop_block", int'(bus.drop_block), 0);
                checkOutput("reset update_board_state", int'(bus.update_board_state), 0);
                checkOutput("reset shift_down", int'(bus.shift_down), 0);
                checkOutput("reset moves", int'({bus.move_left, bus.move_right, bus.rotate}), 0);
                checkOutput("reset game_over", int'(bus.game_over), 0);
                checkOutput("reset lines_cleared", int'(bus.lines_cleared), 0);
            end

            pulses = 0;
            kind   = -1;
            if (bus.rotate === 1'b1)             begin pulses++; kind = K_ROTATE; end
            if (bus.move_right === 1'b1)         begin pulses++; kind = K_RIGHT;  end
            if (bus.move_left === 1'b1)          begin pulses++; kind = K_LEFT;   end
            if (bus.shift_down === 1'b1)         begin pulses++; kind = K_SHIFT;  end
            if (bus.update_board_state === 1'b1) begin pulses++; kind = K_UPDATE; end
            if (bus.drop_block === 1'b1)         begin pulses++; kind = K_DROP;   end
            if (bus.load_block === 1'b1)         begin pulses++; kind = K_LOAD;   end
            if (bus.game_over === 1'b1 && !goPrev && pulses == 0) begin
                pulses = 1;
                kind   = K_OVER;
            end
            goPrev = (bus.game_over === 1'b1);

            if (pulses > 0) begin
                checkOutput("pulses in one cycle", pulses, 1);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected action: got %s, expected no action", kindName(kind));
                end else begin
                    e = sb.pop_front();
                    if (kind != e.kind) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL action order: got %s, expected %s", kindName(kind), kindName(e.kind));
                    end else begin
                        checkOutput({kindName(kind), " seen"}, kind, e.kind);
                    end
                    if (e.kind == K_SHIFT && kind == K_SHIFT)
                        checkOutput("shift_index", int'(bus.shift_index), e.idx);
                    if (e.kind == K_LOAD && kind == K_LOAD)
                        checkOutput("lines_cleared at load", int'(bus.lines_cleared), e.lines);
                end
            end

            if (bus.update_board_state === 1'b1) bus.completed_lines = pendingMask;
            if (bus.shift_down === 1'b1) begin
                m   = bus.completed_lines;
                low = (ROWS'(1) << bus.shift_index) - ROWS'(1);
                bus.completed_lines = (m & low) | ((m >> 1) & ~low);
            end
            if (reset === 1'b1) bus.completed_lines = '0;
            resetPrev = (reset === 1'b1);

            if (doneReq) begin
                checkOutput("scoreboard drained", sb.size(), 0);
                $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
                $finish;
            end
            if (cycles > 50000) begin
                checks++;
                failures++;
                $display("[TB] FAIL timeout: got %0d cycles, expected test end before 50000", cycles);
                $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
                $finish;
            end
        end
    end

endmodule
